serial_frame_receiver: RTL and testbench

//   Receive end of the inter-board serial link: captures FRAME_BITS-bit frames sent as clkIn/dataIn pairs.

---
 rtl/serial_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_serial_frame_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Receive end of the inter-board serial link: oversamples clkIn/dataIn in the clk
// domain, assembles LSB-first frames and double-buffers them behind a valid/ack handshake.
// Optional partial-frame timeout is enabled by defining RX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no frame in progress; first clkIn edge with rxEnable=1 stores bit 0
// RECV  | assembling a frame; bitCount wraps to 0 on the final bit
module serial_frame_receiver #(
    parameter int FRAME_BITS     = 256,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clkIn,
    input  logic                  dataIn,
    input  logic                  rxEnable,
    input  logic                  frameAck,
    output logic [FRAME_BITS-1:0] frameData,
    output logic                  frameValid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeoutErr
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
    logic                    clk_prev_q, clk_prev_d;
    logic [CNT_W-1:0]        bit_count_q, bit_count_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [FRAME_BITS-1:0]   frame_full;
    logic                    clk_s, data_s, bit_edge, complete;

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign bit_edge = clk_s & ~clk_prev_q;

    always_comb begin
        clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], clkIn};
        data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], dataIn};
        clk_prev_d    = clk_s;
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        timeout_err_d = 1'b0;
        complete      = 1'b0;
        frame_full    = shift_q;
        frame_full[bit_count_q] = data_s;

        // rxEnable=0 wins over a coincident edge so an abort never leaves a stray bit
        if (!rxEnable) begin
            state_d     = IDLE;
            bit_count_d = '0;
            overrun_d   = 1'b0;
        end else if (bit_edge) begin
            shift_d[bit_count_q] = data_s;
            if (state_q == IDLE) begin
                state_d     = RECV;
                bit_count_d = CNT_W'(1);
            end else if (bit_count_q == LAST_BIT) begin
                bit_count_d = '0;
                complete    = 1'b1;
            end else begin
                bit_count_d = bit_count_q + CNT_W'(1);
            end
        end
`ifdef RX_TIMEOUT_EN
        else if (state_q == RECV && bit_count_q != '0 && idle_cnt_q == '0) begin
            state_d       = IDLE;
            bit_count_d   = '0;
            timeout_err_d = 1'b1;
        end
`endif

        if (complete) begin
            if (!frame_valid_q || frameAck) begin
                frame_data_d  = frame_full;
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (frameAck && frame_valid_q) begin
            frame_valid_d = 1'b0;
        end

        busy_d = (bit_count_d != '0);
    end

`ifdef RX_TIMEOUT_EN
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (bit_edge)
            idle_cnt_d = TO_LOAD;
        else if (state_q == RECV && bit_count_q != '0 && idle_cnt_q != '0)
            idle_cnt_d = idle_cnt_q - TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_cnt_q <= '0;
        else      idle_cnt_q <= idle_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            clk_sync_q    <= '0;
            data_sync_q   <= '0;
            clk_prev_q    <= 1'b0;
            bit_count_q   <= '0;
            shift_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign frameData  = frame_data_q;
    assign frameValid = frame_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: random frames sent at clk/8 and
// compared against a frame-level model of the handshake/overrun rules.
module tb_serial_frame_receiver;
    localparam int FB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clkIn = 1'b0;
    logic          dataIn = 1'b0;
    logic          rxEnable = 1'b1;
    logic          frameAck = 1'b0;
    logic [FB-1:0] frameData;
    logic          frameValid, busy, overrun, timeoutErr;

    int checks = 0;
    int errors = 0;

    logic [FB-1:0] m_data;
    logic          m_valid, m_overrun;

    serial_frame_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .clkIn(clkIn), .dataIn(dataIn), .rxEnable(rxEnable),
        .frameAck(frameAck), .frameData(frameData), .frameValid(frameValid),
        .busy(busy), .overrun(overrun), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_data = '0; m_valid = 1'b0; m_overrun = 1'b0;
    endtask

    task automatic model_complete(input logic [FB-1:0] f, input bit ack);
        if (!m_valid || ack) begin
            m_data  = f;
            m_valid = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] r;
        for (int w = 0; w < FB / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bit_low(input logic b);
        dataIn = b;
        clkIn  = 1'b0;
        wait_cycles(4);
    endtask

    task automatic bit_high();
        clkIn = 1'b1;
        wait_cycles(4);
    endtask

    task automatic send_bits(input logic [FB-1:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bit_low(f[i]);
            bit_high();
        end
    endtask

    task automatic send_frame(input logic [FB-1:0] f);
        send_bits(f, 0, FB - 1);
        model_complete(f, 1'b0);
    endtask

    task automatic do_ack();
        frameAck = 1'b1;
        wait_cycles(1);
        frameAck = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic pulse_disable();
        rxEnable = 1'b0;
        wait_cycles(2);
        rxEnable = 1'b1;
        m_overrun = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        wait_cycles(3);
        model_reset();
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL reset_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frameValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeoutErr); end
        rst = 1'b1;
        wait_cycles(3);
    endtask

    task automatic test_single_frame();
        logic [FB-1:0] f;
        int n;
        f = '0; f[0] = 1'b1; f[FB-1] = 1'b1;
        send_bits(f, 0, FB - 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b want 1", busy); end
        bit_low(f[FB-1]);
        clkIn = 1'b1;
        n = 0;
        while (frameValid !== 1'b1 && n < 10) begin wait_cycles(1); n++; end
        model_complete(f, 1'b0);
        checks++; if (n !== 3) begin errors++; $display("FAIL single_latency: got %0d cycles want 3", n); end
        wait_cycles(1);
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL single_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL single_valid: got %b want %b", frameValid, m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
        do_ack();
        wait_cycles(1);
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL single_ack: got %b want %b", frameValid, m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] f1, f2;
        f1 = rand_frame();
        f2 = rand_frame();
        send_frame(f1);
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL b2b_overrun_first: got %b want %b", overrun, m_overrun); end
        send_frame(f2);
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL b2b_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL b2b_valid: got %b want %b", frameValid, m_valid); end
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL b2b_overrun: got %b want %b", overrun, m_overrun); end
        do_ack();
        wait_cycles(1);
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL b2b_ack_valid: got %b want %b", frameValid, m_valid); end
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL b2b_overrun_sticky: got %b want %b", overrun, m_overrun); end
    endtask

    task automatic test_ack_on_completion();
        logic [FB-1:0] fa, fb;
        pulse_disable();
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL aoc_overrun_clear: got %b want %b", overrun, m_overrun); end
        fa = rand_frame();
        fb = rand_frame();
        send_frame(fa);
        send_bits(fb, 0, FB - 2);
        bit_low(fb[FB-1]);
        clkIn = 1'b1;
        wait_cycles(2);
        frameAck = 1'b1;
        wait_cycles(1);
        frameAck = 1'b0;
        model_complete(fb, 1'b1);
        wait_cycles(1);
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL aoc_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL aoc_valid: got %b want %b", frameValid, m_valid); end
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL aoc_overrun: got %b want %b", overrun, m_overrun); end
        do_ack();
    endtask

    task automatic test_abort();
        logic [FB-1:0] junk, a5;
        junk = rand_frame();
        for (int i = 0; i < FB / 8; i++) a5[i*8 +: 8] = 8'hA5;
        send_bits(junk, 0, 99);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
        rxEnable = 1'b0;
        wait_cycles(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL abort_valid: got %b want %b", frameValid, m_valid); end
        rxEnable = 1'b1;
        m_overrun = 1'b0;
        send_frame(a5);
        checks++; if (frameData !== a5) begin errors++; $display("FAIL abort_a5_data: got %h want %h", frameData, a5); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL abort_a5_valid: got %b want %b", frameValid, m_valid); end
        do_ack();
    endtask

    task automatic test_stall();
        logic [FB-1:0] f;
        int pulses, pulse_at;
        f = rand_frame();
        send_bits(f, 0, 9);
        pulses = 0;
        pulse_at = -1;
        for (int c = 1; c <= 100; c++) begin
            wait_cycles(1);
            if (timeoutErr === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = c;
            end
        end
`ifdef RX_TIMEOUT_EN
        checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulse_count: got %0d want 1", pulses); end
        checks++; if (pulse_at < 62 || pulse_at > 66) begin errors++; $display("FAIL stall_pulse_time: got %0d want 62..66", pulse_at); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy: got %b want 0", busy); end
`else
        checks++; if (pulses !== 0) begin errors++; $display("FAIL stall_no_timeout: got %0d pulses want 0", pulses); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_hold: got %b want 1", busy); end
        pulse_disable();
`endif
        f = rand_frame();
        send_frame(f);
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL stall_next_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL stall_next_valid: got %b want %b", frameValid, m_valid); end
    endtask

    task automatic test_mid_reset();
        logic [FB-1:0] f;
        f = rand_frame();
        send_bits(f, 0, 149);
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL mrst_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", frameValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mrst_overrun: got %b want 0", overrun); end
        clkIn  = 1'b0;
        dataIn = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(3);
        f = rand_frame();
        send_frame(f);
        checks++; if (frameData !== m_data) begin errors++; $display("FAIL mrst_next_data: got %h want %h", frameData, m_data); end
        checks++; if (frameValid !== m_valid) begin errors++; $display("FAIL mrst_next_valid: got %b want %b", frameValid, m_valid); end
        checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL mrst_next_overrun: got %b want %b", overrun, m_overrun); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ack_on_completion();
        test_abort();
        test_stall();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
